mdu_iter: RTL and testbench

MDU_ITER -- requirements
Module: mdu_iter

---
 rtl/mdu_pkg.sv | 25 ++
 rtl/mdu_if.sv | 19 +
 rtl/mdu_sign_fix.sv | 8 +
 rtl/mdu_iter.sv | 128 ++++++++++++
 tb/tb_mdu_iter.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings and width for the iterative multiply/divide unit.
package mdu_pkg;
    localparam int DW = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic op_signed(op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction
endpackage

// File: rtl/mdu_if.sv
// CPU-side bundle of the MDU: launch, MTHI/MTLO writes, status and HI/LO.
interface mdu_if #(parameter int DW = mdu_pkg::DW);
    logic          start;
    logic [1:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          hi_we;
    logic          lo_we;
    logic [DW-1:0] wdata;
    logic          busy;
    logic          done;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;

    modport master (output start, op, a, b, hi_we, lo_we, wdata,
                    input  busy, done, hi, lo);
    modport slave  (input  start, op, a, b, hi_we, lo_we, wdata,
                    output busy, done, hi, lo);
endinterface

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negation; doubles as abs() when neg = sign bit.
module mdu_sign_fix #(parameter int W = 32) (
    input  logic [W-1:0] din,
    input  logic         neg,
    output logic [W-1:0] dout
);
    assign dout = neg ? (~din + {{(W-1){1'b0}}, 1'b1}) : din;
endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: one bit per cycle on magnitudes,
// signs applied at commit.
module mdu_iter #(parameter int DW = mdu_pkg::DW) (
    input  logic clk,
    input  logic rst_n,
    mdu_if.slave bus
);
    import mdu_pkg::*;

    state_e        state, nstate;
    op_e           op_q;
    logic [DW-1:0] a_q, m_q, acc_hi, acc_lo, hi_r, lo_r;
    logic          neg_res, neg_rem, bzero, fin;
    logic [4:0]    cnt;

    op_e           op_in;
    logic          sgn_in;
    logic [DW-1:0] abs_a, abs_b;

    assign op_in  = op_e'(bus.op);
    assign sgn_in = op_signed(op_in);

    mdu_sign_fix #(.W(DW)) u_abs_a (.din(bus.a), .neg(sgn_in & bus.a[DW-1]), .dout(abs_a));
    mdu_sign_fix #(.W(DW)) u_abs_b (.din(bus.b), .neg(sgn_in & bus.b[DW-1]), .dout(abs_b));

    logic [2*DW-1:0] prod_fix;
    logic [DW-1:0]   quo_fix, rem_fix;

    mdu_sign_fix #(.W(2*DW)) u_fix_p (.din({acc_hi, acc_lo}), .neg(neg_res), .dout(prod_fix));
    mdu_sign_fix #(.W(DW))   u_fix_q (.din(acc_lo), .neg(neg_res), .dout(quo_fix));
    mdu_sign_fix #(.W(DW))   u_fix_r (.din(acc_hi), .neg(neg_rem), .dout(rem_fix));

    // Shared accumulator: multiply shifts {acc_hi,acc_lo} right, divide shifts it left.
    logic [DW:0] mul_sum, div_sh, div_diff;
    logic        div_ge;

    always_comb begin
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m_q} : '0);
        div_sh   = {acc_hi, acc_lo[DW-1]};
        div_diff = div_sh - {1'b0, m_q};
        div_ge   = ~div_diff[DW];
    end

    logic [DW-1:0] res_hi, res_lo;

    always_comb begin
        {res_hi, res_lo} = prod_fix;
        if (op_is_div(op_q)) begin
            if (bzero) {res_hi, res_lo} = {a_q, {DW{1'b1}}};
            else       {res_hi, res_lo} = {rem_fix, quo_fix};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            S_IDLE:  if (bus.start) nstate = S_RUN;
            S_RUN:   if (fin) nstate = S_DONE;
            S_DONE:  nstate = S_IDLE;
            default: nstate = S_IDLE;
        endcase
    end

    // RUN holds 32 iteration cycles plus one commit cycle, so done lands 33 edges after start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= OP_MULT;
            a_q     <= '0;
            m_q     <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            bzero   <= 1'b0;
            fin     <= 1'b0;
            cnt     <= '0;
            hi_r    <= '0;
            lo_r    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.hi_we) hi_r <= bus.wdata;
                    if (bus.lo_we) lo_r <= bus.wdata;
                    if (bus.start) begin
                        op_q    <= op_in;
                        a_q     <= bus.a;
                        m_q     <= op_is_div(op_in) ? abs_b : abs_a;
                        acc_hi  <= '0;
                        acc_lo  <= op_is_div(op_in) ? abs_a : abs_b;
                        neg_res <= sgn_in & (bus.a[DW-1] ^ bus.b[DW-1]);
                        neg_rem <= sgn_in & bus.a[DW-1];
                        bzero   <= (bus.b == '0);
                        fin     <= 1'b0;
                        cnt     <= '0;
                    end
                end
                S_RUN: begin
                    if (!fin) begin
                        if (op_is_div(op_q)) begin
                            acc_hi <= div_ge ? div_diff[DW-1:0] : div_sh[DW-1:0];
                            acc_lo <= {acc_lo[DW-2:0], div_ge};
                        end else begin
                            acc_hi <= mul_sum[DW:1];
                            acc_lo <= {mul_sum[0], acc_lo[DW-1:1]};
                        end
                        cnt <= cnt + 5'd1;
                        fin <= (cnt == 5'd31);
                    end else begin
                        hi_r <= res_hi;
                        lo_r <= res_lo;
                        fin  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != S_IDLE);
    assign bus.done = (state == S_DONE);
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
endmodule

// File: tb/tb_mdu_iter.sv
// Randomized bench for mdu_iter against an arithmetic reference with cycle-accurate timing model.
module tb_mdu_iter;
    import mdu_pkg::*;

    logic clk;
    logic rst_n;
    mdu_if #(.DW(32)) bus ();

    mdu_iter #(.DW(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result {hi,lo} computed from plain integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                                input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: begin p = sa * sb; return p; end
            2'b01: begin p = {32'd0, a} * {32'd0, b}; return p; end
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Timing model: t counts edges since launch; commit at 33, idle at 34.
    bit          mbusy, mdone;
    logic [31:0] mhi, mlo;
    logic [63:0] pend;
    int          t;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mbusy = 1'b0; mdone = 1'b0; mhi = '0; mlo = '0; pend = '0; t = 0;
        end else if (!mbusy) begin
            if (bus.hi_we) mhi = bus.wdata;
            if (bus.lo_we) mlo = bus.wdata;
            if (bus.start) begin
                pend  = ref_result(bus.op, bus.a, bus.b);
                mbusy = 1'b1;
                t     = 0;
            end
        end else begin
            t++;
            if (t == 33) begin
                {mhi, mlo} = pend;
                mdone = 1'b1;
            end else if (t == 34) begin
                mdone = 1'b0;
                mbusy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 64'(bus.busy), 64'(mbusy));
            chk("done", 64'(bus.done), 64'(mdone));
            chk("hi", 64'(bus.hi), 64'(mhi));
            chk("lo", 64'(bus.lo), 64'(mlo));
        end
    end

    // Called at a negedge; launches and watches 40 cycles for the done pulse.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit inject, output int lat, output int pulses);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        lat = 0; pulses = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.done) begin
                pulses++;
                if (lat == 0) lat = k;
            end
            if (k == 1) begin
                bus.start = 1'b0;
                bus.op = 2'($urandom_range(0, 3));
                bus.a = $urandom; bus.b = $urandom;
            end
            if (inject && k == 5) begin
                bus.start = 1'b1; bus.hi_we = 1'b1; bus.wdata = $urandom;
            end
            if (inject && k == 6) begin
                bus.start = 1'b0; bus.hi_we = 1'b0;
            end
        end
    endtask

    task automatic run_dir(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                           input bit inject);
        int lat, pulses;
        @(negedge clk);
        do_op(op, a, b, inject, lat, pulses);
        chk({name, "_lat"}, 64'(lat), 64'd34);
        chk({name, "_pulses"}, 64'(pulses), 64'd1);
        chk({name, "_dut"}, {bus.hi, bus.lo}, {eh, el});
        chk({name, "_model"}, {mhi, mlo}, {eh, el});
    endtask

    task automatic mt(input bit hw, input bit lw, input logic [31:0] d);
        @(negedge clk);
        bus.hi_we = hw; bus.lo_we = lw; bus.wdata = d;
        @(negedge clk);
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0000_0001;
            4: return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat, pulses;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        run_dir("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        run_dir("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_dir("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_dir("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run_dir("divu_zero", OP_DIVU, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b0);
        run_dir("div_zero", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);
        run_dir("inject", OP_MULTU, 32'd7, 32'd6, 32'd0, 32'd42, 1'b1);

        mt(1'b1, 1'b0, 32'h1234_5678);
        chk("mthi", 64'(bus.hi), 64'h1234_5678);
        mt(1'b0, 1'b1, 32'hCAFE_F00D);
        chk("mtlo", {bus.hi, bus.lo}, 64'h1234_5678_CAFE_F00D);
        mt(1'b1, 1'b1, 32'h0BAD_BEEF);
        chk("mthilo", {bus.hi, bus.lo}, 64'h0BAD_BEEF_0BAD_BEEF);

        // MTHI/MTLO coinciding with start: write lands first, commit overwrites later.
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'd3; bus.b = 32'd4;
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hA5A5_0F0F;
        @(negedge clk);
        bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        chk("coinc_mt", {bus.hi, bus.lo}, 64'hA5A5_0F0F_A5A5_0F0F);
        chk("coinc_busy", 64'(bus.busy), 64'd1);
        repeat (33) @(negedge clk);
        chk("coinc_done", 64'(bus.done), 64'd1);
        chk("coinc_res", {bus.hi, bus.lo}, 64'd12);
        repeat (6) @(negedge clk);

        // Reset mid-run aborts; a new op launches on the first edge after release.
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_DIVU; bus.a = $urandom; bus.b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_done", 64'(bus.done), 64'd0);
        chk("arst_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(OP_DIVU, 32'd10, 32'd3, 1'b0, lat, pulses);
        chk("post_rst_lat", 64'(lat), 64'd34);
        chk("post_rst_res", {bus.hi, bus.lo}, {32'd1, 32'd3});

        for (int i = 0; i < 30; i++) begin
            logic [31:0] ra, rb;
            logic [1:0]  rop;
            ra  = pick();
            rb  = pick();
            rop = 2'($urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            @(negedge clk);
            do_op(rop, ra, rb, 1'b0, lat, pulses);
            chk("rand_lat", 64'(lat), 64'd34);
            chk("rand_pulses", 64'(pulses), 64'd1);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
